// File: rtl/melody_sequencer.sv
// Song-RAM melody sequencer driving a square-wave tone generator's note/hush inputs.
// Define MELODY_GAP_EN to silence the final tick of sustained (dur>=2, rest=0) entries.
module melody_sequencer #(
   parameter  int unsigned TICK_DIV = 6_250_000,
   parameter  int unsigned LEN      = 32,
   localparam int unsigned AW       = $clog2(LEN)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   input  logic          stop_i,
   input  logic          loop_i,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [8:0]    wr_data_i,
   output logic [3:0]    note_o,
   output logic          hush_o,
   output logic          busy_o,
   output logic [AW-1:0] step_o
);

   localparam int unsigned   PW       = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PSC_LAST = PW'(TICK_DIV - 1);
   localparam logic [AW-1:0] STEP_END = AW'(LEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] step_q, step_d;
   logic [3:0]    note_q, note_d;
   logic [3:0]    ticks_q, ticks_d;
   logic          hush_q, hush_d;
   logic [PW-1:0] psc_q, psc_d;
   logic [8:0]    ram_q [LEN];
   logic [8:0]    entry;
   logic          tick;
   logic          gap_now;

   // Song RAM: no reset so the tune survives rst; writable only while idle.
   always_ff @(posedge clk_i) begin
      if (wr_en_i && !busy_o) ram_q[wr_addr_i] <= wr_data_i;
   end

   assign entry = ram_q[step_q];
   assign tick  = (psc_q == PSC_LAST);

`ifdef MELODY_GAP_EN
   // In PLAY hush_q equals the entry's rest bit, so it doubles as the rest flag.
   assign gap_now = (state_q == S_PLAY) && (ticks_q == 4'd2) && !hush_q;
`else
   assign gap_now = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      note_d  = note_q;
      ticks_d = ticks_q;
      hush_d  = hush_q;
      psc_d   = psc_q;
      if (stop_i) begin
         state_d = S_IDLE;
         hush_d  = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_d = S_LOAD;
                  step_d  = '0;
               end
            end
            S_LOAD: begin
               note_d  = entry[7:4];
               ticks_d = entry[3:0];
               psc_d   = '0;
               if (entry[3:0] != 4'd0) begin
                  state_d = S_PLAY;
                  hush_d  = entry[8];
               end else if (loop_i && step_q != '0) begin
                  step_d = '0;
               end else begin
                  state_d = S_IDLE;
                  hush_d  = 1'b1;
               end
            end
            S_PLAY, S_GAP: begin
               psc_d = tick ? '0 : psc_q + 1'b1;
               if (tick) begin
                  ticks_d = ticks_q - 4'd1;
                  if (ticks_q == 4'd1) begin
                     step_d = step_q + 1'b1;
                     // Running off the end of the RAM behaves like an end marker.
                     if (step_q == STEP_END && !loop_i) begin
                        state_d = S_IDLE;
                        hush_d  = 1'b1;
                     end else begin
                        state_d = S_LOAD;
                     end
                  end else if (gap_now) begin
                     state_d = S_GAP;
                     hush_d  = 1'b1;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         step_q  <= '0;
         note_q  <= '0;
         ticks_q <= '0;
         hush_q  <= 1'b1;
         psc_q   <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         note_q  <= note_d;
         ticks_q <= ticks_d;
         hush_q  <= hush_d;
         psc_q   <= psc_d;
      end
   end

   assign note_o = note_q;
   assign hush_o = hush_q;
   assign busy_o = (state_q != S_IDLE);
   assign step_o = step_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: a song-schedule model expands each playback into
// per-cycle expected outputs, compared every cycle, plus directed literal checks.
module tb_melody_sequencer;
   localparam int TD    = 4;
   localparam int LEN   = 8;
   localparam int AW    = 3;
   localparam int LIMIT = 2000;
`ifdef MELODY_GAP_EN
   localparam bit GAP = 1'b1;
`else
   localparam bit GAP = 1'b0;
`endif

   typedef struct packed {
      logic [3:0]    note;
      logic          hush;
      logic          busy;
      logic [AW-1:0] step;
   } out_t;
   localparam out_t RST_OUT = {4'd0, 1'b1, 1'b0, 3'd0};

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0, stop = 1'b0, loop_r = 1'b0, wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [8:0]    wr_data = '0;
   logic [3:0]    note;
   logic          hush, busy;
   logic [AW-1:0] step;

   int checks = 0, failures = 0;
   bit chk_en = 1'b0;

   melody_sequencer #(.TICK_DIV(TD), .LEN(LEN)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .loop_i(loop_r),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .note_o(note), .hush_o(hush), .busy_o(busy), .step_o(step)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [8:0] mram [LEN];
   out_t       exp_o = RST_OUT;
   out_t       mq[$];

   // Expand a playback into the outputs expected after each successive edge.
   function automatic void build();
      out_t r; int s; int d; logic [8:0] e;
      s = 0;
      r = exp_o; r.busy = 1'b1; r.step = '0;
      mq.push_back(r);
      while (mq.size() < LIMIT) begin
         e = mram[s]; d = int'(e[3:0]); r.note = e[7:4];
         if (d == 0) begin
            if (loop_r && s != 0) begin
               s = 0; r.step = '0; mq.push_back(r);
               continue;
            end
            r.hush = 1'b1; r.busy = 1'b0; mq.push_back(r);
            return;
         end
         for (int c = 0; c < d * TD; c++) begin
            r.hush = e[8] | (GAP && d >= 2 && c >= (d - 1) * TD);
            mq.push_back(r);
         end
         s = (s + 1) % LEN; r.step = s[AW-1:0];
         if (s == 0 && !loop_r) begin
            r.hush = 1'b1; r.busy = 1'b0; mq.push_back(r);
            return;
         end
         mq.push_back(r);
      end
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_o = RST_OUT;
         mq.delete();
      end else begin
         if (wr_en && !exp_o.busy) mram[wr_addr] = wr_data;
         if (stop) begin
            exp_o.busy = 1'b0; exp_o.hush = 1'b1;
            mq.delete();
         end else if (start && !exp_o.busy) begin
            mq.delete();
            build();
            exp_o = mq.pop_front();
         end else if (mq.size() > 0) begin
            exp_o = mq.pop_front();
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         checks++;
         if ({note, hush, busy, step} !== exp_o) begin
            failures++;
            $display("FAIL outputs t=%0t got note=%0d hush=%0d busy=%0d step=%0d want note=%0d hush=%0d busy=%0d step=%0d",
                     $time, note, hush, busy, step, exp_o.note, exp_o.hush, exp_o.busy, exp_o.step);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input int act, input int want);
      checks++;
      if (act != want) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, want);
      end
   endtask

   task automatic wr(input int a, input logic [8:0] d);
      wr_en = 1'b1; wr_addr = a[AW-1:0]; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int k = 0;
      while (busy && k < bound) begin
         @(negedge clk); k++;
      end
      chk("idle_timeout", int'(busy), 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int bc, h0, s0, r, n, cap;
      logic [AW-1:0] held;
      logic [8:0] ent;

      @(negedge clk);
      chk_en = 1'b1;
      chk("rst_note", int'(note), 0);
      chk("rst_hush", int'(hush), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_step", int'(step), 0);
      rst = 1'b0;
      @(negedge clk);

      // Single note then marker.
      wr(0, 9'h052); wr(1, 9'h000);
      pulse_start();
      bc = 0; h0 = 0;
      for (int i = 0; i < 15; i++) begin
         if (busy) bc++;
         if (i >= 1 && i <= 8 && note == 4'd5 && !hush) h0++;
         if (i == 9) chk("t1_marker_load_busy", int'(busy), 1);
         @(negedge clk);
      end
      chk("t1_busy_cycles", bc, 10);
      chk("t1_sound_cycles", h0, GAP ? 4 : 8);
      chk("t1_end_hush", int'(hush), 1);
      chk("t1_end_busy", int'(busy), 0);

      // Looped two-step song, two full passes.
      wr(0, 9'h131); wr(1, 9'h0C3); wr(2, 9'h000);
      loop_r = 1'b1;
      pulse_start();
      bc = 0; h0 = 0; s0 = 0;
      for (int i = 0; i < 38; i++) begin
         if (busy) bc++;
         if (step == 0) s0++;
         if (i % 19 >= 6 && i % 19 <= 17 && note == 4'd12 && !hush) h0++;
         @(negedge clk);
      end
      chk("t2_busy_cycles", bc, 38);
      chk("t2_step0_cycles", s0, 10);
      chk("t2_note12_cycles", h0, GAP ? 16 : 24);
      stop = 1'b1; @(negedge clk); stop = 1'b0;
      chk("t2_stop_busy", int'(busy), 0);
      loop_r = 1'b0;

      // Stop together with start mid-PLAY, then restart.
      pulse_start();
      repeat (8) @(negedge clk);
      start = 1'b1; stop = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      chk("t3_busy", int'(busy), 0);
      chk("t3_hush", int'(hush), 1);
      chk("t3_step_kept", int'(step), 1);
      @(negedge clk);
      pulse_start();
      chk("t3_restart_step", int'(step), 0);
      chk("t3_restart_busy", int'(busy), 1);
      wait_idle(200);

      // Write while busy must be dropped.
      pulse_start();
      repeat (2) @(negedge clk);
      wr(0, 9'h1FF);
      wait_idle(200);
      pulse_start();
      @(negedge clk);
      chk("t4_note_orig", int'(note), 3);
      chk("t4_hush_orig", int'(hush), 1);
      wait_idle(200);

      // Asynchronous reset mid-note.
      pulse_start();
      repeat (7) @(negedge clk);
      #3 rst = 1'b1;
      #1;
      chk("t5_rst_hush", int'(hush), 1);
      chk("t5_rst_note", int'(note), 0);
      chk("t5_rst_busy", int'(busy), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      pulse_start();
      repeat (7) @(negedge clk);
      chk("t5_ram_kept_note", int'(note), 12);
      chk("t5_ram_kept_hush", int'(hush), 0);
      wait_idle(200);

      // Randomized songs with random stop / ignored start / dropped writes.
      for (int it = 0; it < 30; it++) begin
         for (int a = 0; a < LEN; a++) begin
            ent[8]   = ($urandom_range(0, 3) == 0);
            ent[7:4] = 4'($urandom_range(0, 15));
            ent[3:0] = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 4));
            wr(a, ent);
         end
         loop_r = ($urandom_range(0, 2) == 0);
         @(negedge clk);
         pulse_start();
         n = 0;
         cap = loop_r ? int'($urandom_range(50, 400)) : 1000;
         while (busy && n < cap) begin
            r = int'($urandom_range(0, 99));
            stop    = (r == 0);
            start   = (r >= 1 && r <= 4);
            wr_en   = (r >= 5 && r <= 9);
            wr_addr = AW'($urandom_range(0, LEN - 1));
            wr_data = 9'($urandom_range(0, 511));
            @(negedge clk);
            n++;
         end
         start = 1'b0; stop = 1'b0; wr_en = 1'b0;
         if (busy) begin
            held = step;
            stop = 1'b1; @(negedge clk); stop = 1'b0;
            chk("rnd_stop_step", int'(step), int'(held));
         end
         chk("rnd_idle", int'(busy), 0);
      end

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Plays a short programmed tune by driving the 4-bit `note` select and `hush` inputs of the square-wave tone generator directly downstream. It sits between the board controls and the tone generator. It holds a 32-step song RAM of (rest, note, duration) entries and steps through it on a tempo tick derived from the 100 MHz clock. It supports single-shot or looped playback, a synchronous stop, and RAM writes while idle.

## Interface
- `TICK_DIV`, default 6_250_000: clocks per tempo tick (16 ticks/s at 100 MHz); legal range ≥ 2.
- `LEN`, default 32: song RAM depth; must be a power of two; address width `AW` = log2(LEN) = 5.
- `clk` in 1: 100 MHz system clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to begin playback from step 0.
- `stop` in 1: synchronous abort to idle.
- `loop` in 1: level; when 1, playback restarts at step 0 after end of song.
- `wr_en` in 1: song RAM write strobe.
- `wr_addr` in AW: RAM write address.
- `wr_data` in 9: entry {rest[8], note[7:4], dur[3:0]}.
- `note` out 4: note select to the tone generator.
- `hush` out 1: 1 = tone generator silent.
- `busy` out 1: 1 while not IDLE.
- `step` out AW: index of the entry currently loaded.

## Operation
- States:
  - IDLE: hush=1, busy=0.
  - LOAD: one cycle; reads RAM[step].
  - PLAY: entry sounding.
  - GAP: articulation silence.
- IDLE → LOAD when `start`=1. On that transition `step` is cleared to 0.
- In LOAD, the block latches `note`, `rest`, and `ticks_left`=dur, and clears the prescaler.
  - If dur≠0: go to PLAY, with hush = rest.
  - If dur=0, the entry is an end marker:
    - if loop=1 and step≠0: step←0 and stay in LOAD;
    - otherwise go to IDLE. A marker at step 0 always ends playback, which prevents an empty loop.
- PLAY/GAP:
  - The prescaler counts 0..TICK_DIV−1. Its terminal count is one tick, and each tick decrements `ticks_left`.
  - When `ticks_left` would reach 0: step←step+1 (mod LEN) and go to LOAD.
  - Wrap from LEN−1 to 0 is treated as end of song, using the same rule as a dur=0 marker applied at step 0 with the loop check.
- `note` holds its last value in IDLE and GAP; only `hush` mutes.
- `stop`=1 in any state: IDLE on the next edge, with hush=1 and step unchanged. If `start` and `stop` are asserted in the same cycle, stop wins.
- `start` while busy is ignored.
- RAM writes:
  - Accepted only when busy=0. Writes while busy are dropped.
  - The RAM is not reset; contents survive `rst`.
- Reset values: `note`=0, `hush`=1, `busy`=0, `step`=0, state IDLE, prescaler 0, `ticks_left` 0.
- Reset mid-playback silences the output asynchronously (hush=1 immediately).

## Timing
- All outputs are registered.
- `start` sampled at edge n → LOAD during cycle n+1 (busy=1). `note`/`hush` for step 0 are valid from edge n+2.
- Each step occupies exactly 1 + dur×TICK_DIV clocks: one LOAD cycle plus dur ticks.
- An end marker costs one LOAD cycle; after it, busy=0 from the following edge.
- `stop` → hush=1 and busy=0 one edge later.
- A write at edge n is readable by a LOAD at n+1 or later.

## Configuration
- `MELODY_GAP_EN` defined:
  - For entries with dur≥2 and rest=0, the final tick of the entry is played in GAP with hush=1. This separates repeated notes.
  - dur=1 entries have no gap.
  - Step length is unchanged.
- Undefined: the GAP state does not exist, and hush = rest for the full dur×TICK_DIV clocks.

## Test plan
- TICK_DIV=4; RAM {0:(0,5,2), 1:(0,0,0)}; pulse start, no gap →
  - hush=0 with note=5 for 8 clocks starting 2 edges after start;
  - then one LOAD cycle;
  - then busy=0 and hush=1.
- Same stimulus with MELODY_GAP_EN → note=5 with hush=0 for 4 clocks, then hush=1 for 4 clocks, then idle.
- RAM {0:(1,3,1), 1:(0,12,3), 2:(0,0,0)}, loop=1 →
  - hush=1 for 4 clocks;
  - note=12 for 12 clocks;
  - marker LOAD;
  - step returns to 0, with busy held at 1 across two full passes.
- stop asserted mid-PLAY together with start → hush=1 and busy=0 next edge; step retains its value; a later start restarts at step 0.
- wr_en while busy writes 0x1FF to the current address → ignored; after idle, reading via playback shows the original entry.
- rst asserted mid-note → hush=1 immediately, note=0, busy=0; RAM contents intact on the next play.
